// File: rtl/sha256d_nonce_scanner.sv
// Double-SHA-256 proof-of-work scanner. It compresses header block 1 once into a cached midstate,
// then sweeps nonces through block 2 plus the second hash, comparing the byte-reversed digest with target.
module sha256d_nonce_scanner #(
  parameter int RPC        = 1,
  parameter int NONCE_STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  cur_nonce
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("sha256d_nonce_scanner: RPC must be 1, 2 or 4");
  end

  localparam int          ROUND_CYCLES = 64 / RPC;
  localparam logic [6:0]  LAST_STEP    = 7'(ROUND_CYCLES + 1);
  localparam logic [31:0] STEP_V       = 32'(NONCE_STEP);

  typedef enum logic [2:0] {S_IDLE, S_MID, S_B2, S_DBL, S_CHK} state_e;
  typedef logic [15:0][31:0] win_t;   // [0] = oldest schedule word W[t]
  typedef logic [7:0][31:0]  work_t;  // [0] = a / H0 ... [7] = h / H7

  localparam work_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                          32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic work_t sha_round(input work_t s, input logic [31:0] kt, input logic [31:0] wt);
    logic [31:0] t1;
    logic [31:0] t2;
    work_t       r;
    t1   = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + kt + wt;
    t2   = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[7] = s[6];
    r[6] = s[5];
    r[5] = s[4];
    r[4] = s[3] + t1;
    r[3] = s[2];
    r[2] = s[1];
    r[1] = s[0];
    r[0] = t1 + t2;
    return r;
  endfunction

  // RPC rounds chained combinationally; round j consumes window word j.
  function automatic work_t do_rounds(input work_t s, input win_t w, input logic [5:0] t0);
    for (int j = 0; j < RPC; j++) begin
      s = sha_round(s, K[t0 + 6'(j)], w[j]);
    end
    return s;
  endfunction

  function automatic win_t next_window(input win_t w);
    logic [31:0] nw;
    for (int k = 0; k < RPC; k++) begin
      nw = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
      w  = {nw, w[15:1]};
    end
    return w;
  endfunction

  state_e         state_q, state_d;
  logic [6:0]     step_q, step_d;
  logic [31:0]    nonce_q, nonce_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic [31:0]    found_nonce_q, found_nonce_d;
  logic [255:0]   found_hash_q, found_hash_d;

  logic [607:0]   hdr_q, hdr_d;
  logic [31:0]    nonce_end_q, nonce_end_d;
  logic [255:0]   target_q, target_d;
  win_t           w_q, w_d;
  work_t          wk_q, wk_d;
  work_t          h_q, h_d;
  work_t          mid_q, mid_d;

  win_t           load_words;
  work_t          load_cv;
  work_t          round_out;
  win_t           win_next;
  work_t          digest;
  logic [5:0]     t_base;
  logic [255:0]   raw_hash;
  logic [255:0]   hash_le;
  logic           unused_nonce_field;

  assign unused_nonce_field = ^header[31:0];

  // Message block and chaining value presented at the load cycle of each compression.
  always_comb begin
    load_words = '0;
    load_cv    = IV;
    case (state_q)
      S_MID: begin
        for (int i = 0; i < 16; i++) load_words[i] = hdr_q[607 - 32*i -: 32];
      end
      S_B2: begin
        load_words[0]  = hdr_q[95:64];
        load_words[1]  = hdr_q[63:32];
        load_words[2]  = hdr_q[31:0];
        load_words[3]  = bswap32(nonce_q);
        load_words[4]  = 32'h80000000;
        load_words[15] = 32'h00000280;
        load_cv        = mid_q;
      end
      S_DBL: begin
        for (int i = 0; i < 8; i++) load_words[i] = h_q[i];
        load_words[8]  = 32'h80000000;
        load_words[15] = 32'h00000100;
      end
      default: ;
    endcase
  end

  always_comb begin
    t_base    = 6'(int'(step_q - 7'd1) * RPC);
    round_out = do_rounds(wk_q, w_q, t_base);
    win_next  = next_window(w_q);
    raw_hash  = '0;
    hash_le   = '0;
    for (int i = 0; i < 8; i++) begin
      digest[i]                 = h_q[i] + wk_q[i];
      raw_hash[255 - 32*i -: 32] = h_q[i];
    end
    for (int b = 0; b < 32; b++) hash_le[8*b +: 8] = raw_hash[255 - 8*b -: 8];
  end

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    nonce_d       = nonce_q;
    done_d        = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    hdr_d         = hdr_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    w_d           = w_q;
    wk_d          = wk_q;
    h_d           = h_q;
    mid_d         = mid_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hdr_d         = header[639:32];
            nonce_d       = nonce_start;
            nonce_end_d   = nonce_end;
            target_d      = target;
            found_d       = 1'b0;
            found_nonce_d = '0;
            found_hash_d  = '0;
            step_d        = '0;
            state_d       = S_MID;
          end
        end
        S_MID, S_B2, S_DBL: begin
          if (step_q == 7'd0) begin
            step_d = 7'd1;
            w_d    = load_words;
            h_d    = load_cv;
            wk_d   = load_cv;
          end else if (step_q == LAST_STEP) begin
            step_d = '0;
            if (state_q == S_MID) begin
              mid_d   = digest;
              state_d = S_B2;
            end else begin
              h_d     = digest;
              state_d = (state_q == S_B2) ? S_DBL : S_CHK;
            end
          end else begin
            step_d = step_q + 7'd1;
            wk_d   = round_out;
            w_d    = win_next;
          end
        end
        S_CHK: begin
          if (hash_le <= target_q) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = raw_hash;
            done_d        = 1'b1;
            state_d       = S_IDLE;
          end else if (nonce_q == nonce_end_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            nonce_d = nonce_q + STEP_V;
            state_d = S_B2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments make all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      nonce_q       <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      nonce_q       <= nonce_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
    end
  end

  // NOTE: datapath and captured operands carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    hdr_q       <= hdr_d;
    nonce_end_q <= nonce_end_d;
    target_q    <= target_d;
    w_q         <= w_d;
    wk_q        <= wk_d;
    h_q         <= h_d;
    mid_q       <= mid_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign cur_nonce   = nonce_q;

endmodule

// File: tb/tb_sha256d_nonce_scanner.sv
// Directed bench for sha256d_nonce_scanner: RPC=1/2/4 instances share stimulus; results are
// checked against hand-known genesis values and a behavioural double-SHA-256 model.
module tb_sha256d_nonce_scanner;

  localparam logic [639:0] GENESIS = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_00000000;
  localparam logic [255:0] GEN_LE  = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam int           RC [3]  = '{66, 34, 18};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [639:0] header = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target = '0;
  logic [2:0]   busy_v, done_v, found_v;
  logic [31:0]  fnonce_v [3];
  logic [31:0]  cur_v [3];
  logic [255:0] fhash_v [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cur_log [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256d_nonce_scanner #(.RPC(1 << g), .NONCE_STEP(1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .header      (header),
      .nonce_start (nonce_start),
      .nonce_end   (nonce_end),
      .target      (target),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .found       (found_v[g]),
      .found_nonce (fnonce_v[g]),
      .found_hash  (fhash_v[g]),
      .cur_nonce   (cur_v[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = x[255 - 8*b -: 8];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Raw {H0..H7} of sha256(sha256(80-byte header with the given nonce)).
  function automatic logic [255:0] sha256d(input logic [639:0] hdr, input logic [31:0] nonce);
    logic [639:0] m;
    logic [255:0] h1;
    m  = {hdr[639:32], bs32(nonce)};
    h1 = compress(IV256, m[639:128]);
    h1 = compress(h1, {m[127:0], 32'h80000000, 320'h0, 32'h00000280});
    return compress(IV256, {h1, 32'h80000000, 192'h0, 32'h00000100});
  endfunction

  task automatic run_scan(input string tag, input logic [639:0] hdr, input logic [31:0] ns,
                          input logic [31:0] ne, input logic [255:0] tg, input int n_tried,
                          input logic exp_found, input logic [31:0] exp_nonce,
                          input logic [255:0] exp_hash, input int poke_at);
    int cnt;
    int budget;
    int lat [3];
    bit seen [3];
    @(negedge clk);
    header = hdr; nonce_start = ns; nonce_end = ne; target = tg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    cur_log.delete();
    cur_log.push_back(cur_v[0]);
    check({tag, " busy_at_start"}, busy_v, 3'b111);
    check({tag, " found_cleared"}, found_v, 3'b000);
    check({tag, " fnonce_cleared"}, fnonce_v[0], 32'h0);
    check({tag, " fhash_cleared"}, fhash_v[0], 256'h0);
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0;
      lat[i]  = 0;
    end
    budget = RC[0] + n_tried * (2 * RC[0] + 1) + 20;
    while (!(seen[0] && seen[1] && seen[2]) && cnt < budget) begin
      if (cnt == poke_at) begin
        start = 1'b1; nonce_start = ns + 32'd5; target = '1; header = ~hdr;
      end
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (busy_v[0] && cur_log[$] != cur_v[0]) cur_log.push_back(cur_v[0]);
      for (int i = 0; i < 3; i++) begin
        if (done_v[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = cnt;
          check($sformatf("%s r%0d found", tag, 1 << i), found_v[i], exp_found);
          check($sformatf("%s r%0d found_nonce", tag, 1 << i), fnonce_v[i], exp_nonce);
          check($sformatf("%s r%0d found_hash", tag, 1 << i), fhash_v[i], exp_hash);
          check($sformatf("%s r%0d idle_at_done", tag, 1 << i), busy_v[i], 1'b0);
        end
      end
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("%s r%0d latency", tag, 1 << i), lat[i], RC[i] + n_tried * (2 * RC[i] + 1));
    @(negedge clk);
    check({tag, " done_one_cycle"}, done_v, 3'b000);
  endtask

  initial begin
    logic [31:0]  exp_seq [3];
    logic [255:0] gen_raw;
    logic [255:0] h3;
    int           dcount;

    gen_raw = bswap256(GEN_LE);
    h3      = sha256d(GENESIS, 32'h12345678);
    check("model_genesis", sha256d(GENESIS, 32'h7C2BAC1D), gen_raw);

    repeat (3) @(negedge clk);
    check("reset busy/done/found", {busy_v, done_v, found_v}, 9'h0);
    check("reset found_nonce", fnonce_v[0], 32'h0);
    check("reset found_hash", fhash_v[0], 256'h0);
    check("reset cur_nonce", cur_v[0], 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan("genesis", GENESIS, 32'h7C2BAC1A, 32'h7C2BAC1F, 256'hffff << 208, 4,
             1'b1, 32'h7C2BAC1D, gen_raw, -1);

    run_scan("miss3", GENESIS, 32'h7C2BAC1A, 32'h7C2BAC1C, 256'h0, 3, 1'b0, 32'h0, 256'h0, 100);
    check("miss3 cur_hold", cur_v[0], 32'h7C2BAC1C);

    run_scan("ones", GENESIS, 32'h12345678, 32'h12345678, '1, 1, 1'b1, 32'h12345678, h3, -1);

    run_scan("wrap", GENESIS, 32'hFFFFFFFF, 32'h00000001, 256'h0, 3, 1'b0, 32'h0, 256'h0, -1);
    exp_seq = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    check("wrap log_len", cur_log.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("wrap cur[%0d]", k), (k < cur_log.size()) ? cur_log[k] : 32'hDEADBEEF, exp_seq[k]);
    check("wrap cur_hold", cur_v[0], 32'h1);

    // Abort beats start in the same IDLE cycle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_vs_start busy", busy_v, 3'b000);

    // Abort 200 cycles into a scan on the RPC=1/2 instances.
    header = GENESIS; nonce_start = 32'h7C2BAC1A; nonce_end = 32'h7C2BAC1F; target = 256'hffff << 208;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    repeat (199) begin
      @(negedge clk);
      if (done_v[0] || done_v[1]) dcount++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy_drop", busy_v[1:0], 2'b00);
    check("abort found_zero", found_v[1:0], 2'b00);
    repeat (400) begin
      @(negedge clk);
      if (done_v[0] || done_v[1]) dcount++;
    end
    check("abort no_done", dcount, 0);

    run_scan("after_abort", GENESIS, 32'h7C2BAC1A, 32'h7C2BAC1F, 256'hffff << 208, 4,
             1'b1, 32'h7C2BAC1D, gen_raw, -1);

    // Reset asserted while the RPC=1 instance is in the second hash.
    header = GENESIS; nonce_start = 32'h7C2BAC1A; nonce_end = 32'h7C2BAC1F; target = 256'hffff << 208;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    check("pre_reset busy", busy_v, 3'b111);
    check("pre_reset cur", cur_v[0], 32'h7C2BAC1A);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset busy/done/found", {busy_v, done_v, found_v}, 9'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_reset r%0d cur", 1 << i), cur_v[i], 32'h0);
      check($sformatf("mid_reset r%0d fnonce", 1 << i), fnonce_v[i], 32'h0);
      check($sformatf("mid_reset r%0d fhash", 1 << i), fhash_v[i], 256'h0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset idle", busy_v, 3'b000);

    run_scan("ones_again", GENESIS, 32'h12345678, 32'h12345678, '1, 1, 1'b1, 32'h12345678, h3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
